// File: rtl/mem_stage_nlane.sv
// N-lane memory stage: waits per lane for the data-cache response, aligns load data,
// holds captured results across writeback stalls and drops responses of squashed loads.
package mem_stage_pkg;
  typedef struct packed {
    logic        lane_valid;
    logic [6:0]  load_type;
    logic [1:0]  offset;
    logic        res_from_mem;
    logic        mem_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rt_value;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } lane_req_t;
endpackage

module mem_lane import mem_stage_pkg::*; #(
  parameter int DROP_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic        leave,
  input  logic        ms_valid,
  input  lane_req_t   req_in,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        lane_ready,
  output logic        lane_valid,
  output logic        gr_we,
  output logic [4:0]  dest,
  output logic [31:0] pc,
  output logic        fwd_from_mem,
  output logic [31:0] result
);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  lane_req_t         req_q;
  logic              cap_ok;
  logic [31:0]       cap_data;
  logic [DROP_W-1:0] drop_cnt;
  logic              needs_mem, accepted, abandon, stale;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       lwl_res, lwr_res, aligned;

  always_ff @(posedge clk) begin
    if (load) req_q <= req_in;
  end

  assign needs_mem  = ms_valid & req_q.lane_valid & (req_q.res_from_mem | req_q.mem_we);
  assign accepted   = needs_mem & ~cap_ok & data_ok & (drop_cnt == '0);
  assign lane_ready = ~needs_mem | cap_ok | accepted;
  // A flushed lane still owes the cache one response unless it already got it.
  assign abandon    = flush & needs_mem & ~cap_ok & ~accepted;
  assign stale      = data_ok & (drop_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset || flush || load) begin
      cap_ok <= 1'b0;
    end else if (accepted && !leave) begin
      cap_ok   <= 1'b1;
      cap_data <= aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (abandon && !stale) begin
      if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
    end else if (stale && !abandon) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_comb begin
    byte_sel = rdata[{req_q.offset, 3'b000} +: 8];
    half_sel = req_q.offset[1] ? rdata[31:16] : rdata[15:0];
    unique case (req_q.offset)
      2'd0:    lwl_res = {rdata[7:0],  req_q.rt_value[23:0]};
      2'd1:    lwl_res = {rdata[15:0], req_q.rt_value[15:0]};
      2'd2:    lwl_res = {rdata[23:0], req_q.rt_value[7:0]};
      default: lwl_res = rdata;
    endcase
    unique case (req_q.offset)
      2'd0:    lwr_res = rdata;
      2'd1:    lwr_res = {req_q.rt_value[31:24], rdata[31:8]};
      2'd2:    lwr_res = {req_q.rt_value[31:16], rdata[31:16]};
      default: lwr_res = {req_q.rt_value[31:8],  rdata[31:24]};
    endcase
    aligned = rdata;
    if      (req_q.load_type[6]) aligned = {{24{byte_sel[7]}}, byte_sel};
    else if (req_q.load_type[5]) aligned = {24'd0, byte_sel};
    else if (req_q.load_type[4]) aligned = {{16{half_sel[15]}}, half_sel};
    else if (req_q.load_type[3]) aligned = {16'd0, half_sel};
    else if (req_q.load_type[2]) aligned = rdata;
    else if (req_q.load_type[1]) aligned = lwl_res;
    else if (req_q.load_type[0]) aligned = lwr_res;
  end

  assign result       = ~req_q.res_from_mem ? req_q.alu_result : cap_ok ? cap_data : aligned;
  assign lane_valid   = req_q.lane_valid;
  assign gr_we        = req_q.lane_valid & req_q.gr_we;
  assign dest         = req_q.dest;
  assign pc           = req_q.pc;
  assign fwd_from_mem = req_q.lane_valid & req_q.res_from_mem;
endmodule

module mem_stage_nlane import mem_stage_pkg::*; #(
  parameter int LANES  = 2,
  parameter int DROP_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ms_flush,
  input  logic                   pms_to_ms_valid,
  output logic                   ms_allowin,
  input  logic [LANES-1:0]       pms_lane_valid,
  input  logic [LANES-1:0][6:0]  pms_load_type,
  input  logic [LANES-1:0][1:0]  pms_offset,
  input  logic [LANES-1:0]       pms_res_from_mem,
  input  logic [LANES-1:0]       pms_mem_we,
  input  logic [LANES-1:0]       pms_gr_we,
  input  logic [LANES-1:0][4:0]  pms_dest,
  input  logic [LANES-1:0][31:0] pms_rt_value,
  input  logic [LANES-1:0][31:0] pms_alu_result,
  input  logic [LANES-1:0][31:0] pms_pc,
  input  logic [LANES-1:0]       data_cache_data_ok,
  input  logic [LANES-1:0][31:0] data_cache_rdata,
  input  logic                   ws_allowin,
  output logic                   ms_to_ws_valid,
  output logic [LANES-1:0]       ms_lane_valid,
  output logic [LANES-1:0]       ms_gr_we,
  output logic [LANES-1:0][4:0]  ms_dest,
  output logic [LANES-1:0][31:0] ms_result,
  output logic [LANES-1:0][31:0] ms_pc,
  output logic                   ms_fwd_valid,
  output logic [LANES-1:0]       ms_fwd_ready,
  output logic [LANES-1:0]       ms_fwd_from_mem
);
  logic                  ms_valid, ms_ready_go, load, leave;
  logic [LANES-1:0]      lane_ready;
  lane_req_t [LANES-1:0] req_in;

  assign ms_ready_go    = &lane_ready;
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~ms_flush;
  assign leave          = ms_to_ws_valid & ws_allowin;
  assign load           = pms_to_ms_valid & ms_allowin & ~ms_flush;
  assign ms_fwd_valid   = ms_valid;
  assign ms_fwd_ready   = lane_ready;

  always_ff @(posedge clk) begin
    if (reset || ms_flush) ms_valid <= 1'b0;
    else if (ms_allowin)   ms_valid <= pms_to_ms_valid;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign req_in[i] = '{lane_valid:   pms_lane_valid[i],
                         load_type:    pms_load_type[i],
                         offset:       pms_offset[i],
                         res_from_mem: pms_res_from_mem[i],
                         mem_we:       pms_mem_we[i],
                         gr_we:        pms_gr_we[i],
                         dest:         pms_dest[i],
                         rt_value:     pms_rt_value[i],
                         alu_result:   pms_alu_result[i],
                         pc:           pms_pc[i]};

    mem_lane #(.DROP_W(DROP_W)) u_lane (
      .clk          (clk),
      .reset        (reset),
      .flush        (ms_flush),
      .load         (load),
      .leave        (leave),
      .ms_valid     (ms_valid),
      .req_in       (req_in[i]),
      .data_ok      (data_cache_data_ok[i]),
      .rdata        (data_cache_rdata[i]),
      .lane_ready   (lane_ready[i]),
      .lane_valid   (ms_lane_valid[i]),
      .gr_we        (ms_gr_we[i]),
      .dest         (ms_dest[i]),
      .pc           (ms_pc[i]),
      .fwd_from_mem (ms_fwd_from_mem[i]),
      .result       (ms_result[i])
    );
  end
endmodule

// File: tb/tb_mem_stage_nlane.sv
// Bench for mem_stage_nlane: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level reference model.
module tb_mem_stage_nlane;
  localparam int L  = 4;
  localparam int DW = 2;
  localparam int DMAX = (1 << DW) - 1;
  localparam logic [6:0] LB = 7'h40, LHU = 7'h08, LW = 7'h04, LWL = 7'h02;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ms_flush, pms_to_ms_valid, ws_allowin;
  logic [L-1:0]       pms_lane_valid, pms_res_from_mem, pms_mem_we, pms_gr_we, data_cache_data_ok;
  logic [L-1:0][6:0]  pms_load_type;
  logic [L-1:0][1:0]  pms_offset;
  logic [L-1:0][4:0]  pms_dest;
  logic [L-1:0][31:0] pms_rt_value, pms_alu_result, pms_pc, data_cache_rdata;
  logic ms_allowin, ms_to_ws_valid, ms_fwd_valid;
  logic [L-1:0]       ms_lane_valid, ms_gr_we, ms_fwd_ready, ms_fwd_from_mem;
  logic [L-1:0][4:0]  ms_dest;
  logic [L-1:0][31:0] ms_result, ms_pc;

  mem_stage_nlane #(.LANES(L), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset), .ms_flush(ms_flush),
    .pms_to_ms_valid(pms_to_ms_valid), .ms_allowin(ms_allowin),
    .pms_lane_valid(pms_lane_valid), .pms_load_type(pms_load_type), .pms_offset(pms_offset),
    .pms_res_from_mem(pms_res_from_mem), .pms_mem_we(pms_mem_we), .pms_gr_we(pms_gr_we),
    .pms_dest(pms_dest), .pms_rt_value(pms_rt_value), .pms_alu_result(pms_alu_result),
    .pms_pc(pms_pc), .data_cache_data_ok(data_cache_data_ok), .data_cache_rdata(data_cache_rdata),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_lane_valid(ms_lane_valid),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_ready(ms_fwd_ready), .ms_fwd_from_mem(ms_fwd_from_mem)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: the group in MEM, per-lane captured result, pending stale responses.
  bit          m_valid = 1'b0;
  bit          m_cap[L];
  logic [31:0] m_capv[L];
  int          m_drop[L];
  logic        g_lv[L], g_rfm[L], g_we[L], g_gr[L];
  logic [6:0]  g_lt[L];
  logic [1:0]  g_off[L];
  logic [4:0]  g_dest[L];
  logic [31:0] g_rt[L], g_alu[L], g_pc[L];

  function automatic logic [31:0] ref_align(logic [6:0] lt, logic [1:0] o, logic [31:0] r, logic [31:0] rt);
    int s;
    logic [31:0] b, h;
    s = int'(o);
    b = (r >> (8 * s)) & 32'hFF;
    h = (r >> (16 * (s / 2))) & 32'hFFFF;
    if (lt[6]) return b[7] ? (b | 32'hFFFF_FF00) : b;
    if (lt[5]) return b;
    if (lt[4]) return h[15] ? (h | 32'hFFFF_0000) : h;
    if (lt[3]) return h;
    if (lt[1]) return (r << (8 * (3 - s))) | (rt & ((32'h1 << (8 * (3 - s))) - 32'h1));
    if (lt[0]) return (r >> (8 * s)) | (rt & ~(32'hFFFF_FFFF >> (8 * s)));
    return r;
  endfunction

  task automatic model_cycle();
    bit need[L], got[L], rdy[L];
    bit all_rdy, e_allow, e_tows, leave, load, inc, dec;
    logic [31:0] al[L];
    all_rdy = 1'b1;
    for (int i = 0; i < L; i++) begin
      need[i] = m_valid && g_lv[i] && (g_rfm[i] || g_we[i]);
      got[i]  = need[i] && !m_cap[i] && data_cache_data_ok[i] && (m_drop[i] == 0);
      rdy[i]  = !need[i] || m_cap[i] || got[i];
      all_rdy = all_rdy && rdy[i];
      al[i]   = ref_align(g_lt[i], g_off[i], data_cache_rdata[i], g_rt[i]);
    end
    e_allow = !m_valid || (all_rdy && ws_allowin);
    e_tows  = m_valid && all_rdy && !ms_flush;
    chk("allowin", ms_allowin, e_allow);
    chk("to_ws_valid", ms_to_ws_valid, e_tows);
    chk("fwd_valid", ms_fwd_valid, m_valid);
    if (m_valid) begin
      for (int i = 0; i < L; i++) begin
        chk($sformatf("lane_valid%0d", i), ms_lane_valid[i], g_lv[i]);
        if (g_lv[i]) begin
          chk($sformatf("gr_we%0d", i), ms_gr_we[i], g_gr[i]);
          chk($sformatf("dest%0d", i), ms_dest[i], g_dest[i]);
          chk($sformatf("pc%0d", i), ms_pc[i], g_pc[i]);
          chk($sformatf("fwd_from_mem%0d", i), ms_fwd_from_mem[i], g_rfm[i]);
          chk($sformatf("fwd_ready%0d", i), ms_fwd_ready[i], rdy[i]);
          if (rdy[i])
            chk($sformatf("result%0d", i), ms_result[i],
                !g_rfm[i] ? g_alu[i] : m_cap[i] ? m_capv[i] : al[i]);
        end
      end
    end
    if (reset) begin
      m_valid = 1'b0;
      for (int i = 0; i < L; i++) begin m_cap[i] = 1'b0; m_drop[i] = 0; end
    end else begin
      leave = e_tows && ws_allowin;
      load  = pms_to_ms_valid && e_allow && !ms_flush;
      for (int i = 0; i < L; i++) begin
        inc = ms_flush && need[i] && !m_cap[i] && !got[i];
        dec = data_cache_data_ok[i] && (m_drop[i] > 0);
        if (inc && !dec && m_drop[i] < DMAX) m_drop[i]++;
        else if (dec && !inc) m_drop[i]--;
        if (ms_flush || load) m_cap[i] = 1'b0;
        else if (got[i] && !leave) begin m_cap[i] = 1'b1; m_capv[i] = al[i]; end
        if (load) begin
          g_lv[i] = pms_lane_valid[i];  g_rfm[i] = pms_res_from_mem[i];
          g_we[i] = pms_mem_we[i];      g_gr[i]  = pms_gr_we[i];
          g_lt[i] = pms_load_type[i];   g_off[i] = pms_offset[i];
          g_dest[i] = pms_dest[i];      g_rt[i]  = pms_rt_value[i];
          g_alu[i]  = pms_alu_result[i]; g_pc[i] = pms_pc[i];
        end
      end
      m_valid = ms_flush ? 1'b0 : e_allow ? pms_to_ms_valid : m_valid;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; ms_flush = 1'b0; pms_to_ms_valid = 1'b0; ws_allowin = 1'b1;
    pms_lane_valid = '0; pms_load_type = '0; pms_offset = '0; pms_res_from_mem = '0;
    pms_mem_we = '0; pms_gr_we = '0; pms_dest = '0; pms_rt_value = '0;
    pms_alu_result = '0; pms_pc = '0; data_cache_data_ok = '0; data_cache_rdata = '0;
  endtask

  task automatic lane(int i, logic [6:0] lt, logic [1:0] o, logic [31:0] rt, logic [31:0] alu);
    pms_lane_valid[i] = 1'b1;  pms_load_type[i] = lt;  pms_res_from_mem[i] = (lt != 7'd0);
    pms_gr_we[i] = 1'b1;       pms_offset[i] = o;      pms_rt_value[i] = rt;
    pms_alu_result[i] = alu;   pms_dest[i] = 5'(i + 1); pms_pc[i] = 32'h1000 + 32'(i * 4);
  endtask

  task automatic resp(int i, logic [31:0] d);
    data_cache_data_ok[i] = 1'b1;
    data_cache_rdata[i]   = d;
  endtask

  initial begin
    for (int i = 0; i < L; i++) begin m_cap[i] = 1'b0; m_drop[i] = 0; end
    idle(); reset = 1'b1; step(); step();
    idle(); #1;
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_to_ws", ms_to_ws_valid, 1'b0);
    chk("rst_fwd_valid", ms_fwd_valid, 1'b0);
    step();

    // lb with sign extension next to an ALU lane
    idle(); pms_to_ms_valid = 1'b1; lane(0, LB, 2'd3, 32'h0, 32'h0); lane(1, 7'd0, 2'd0, 32'h0, 32'h1111); step();
    idle(); step();
    idle(); resp(0, 32'h80AA_BBCC); #1;
    chk("t1_to_ws", ms_to_ws_valid, 1'b1);
    chk("t1_r0", ms_result[0], 32'hFFFF_FF80);
    chk("t1_r1", ms_result[1], 32'h1111);
    step();

    // lwl merge held across a 3-cycle writeback stall
    idle(); pms_to_ms_valid = 1'b1; lane(0, LWL, 2'd1, 32'h1122_3344, 32'h0); step();
    idle(); ws_allowin = 1'b0; resp(0, 32'hAABB_CCDD); #1;
    chk("t2_r0", ms_result[0], 32'hCCDD_3344);
    step();
    for (int k = 0; k < 2; k++) begin
      idle(); ws_allowin = 1'b0; #1;
      chk("t2_hold", ms_result[0], 32'hCCDD_3344);
      chk("t2_stall_allowin", ms_allowin, 1'b0);
      step();
    end
    idle(); #1;
    chk("t2_final", ms_result[0], 32'hCCDD_3344);
    chk("t2_leave_allowin", ms_allowin, 1'b1);
    step();

    // out-of-order completion
    idle(); pms_to_ms_valid = 1'b1; lane(0, LW, 2'd0, 32'h0, 32'h0); lane(1, LW, 2'd0, 32'h0, 32'h0); step();
    idle(); resp(1, 32'h5555_AAAA); #1; chk("t3_c1", ms_to_ws_valid, 1'b0); step();
    for (int k = 0; k < 2; k++) begin idle(); #1; chk("t3_wait", ms_to_ws_valid, 1'b0); step(); end
    idle(); resp(0, 32'h0102_0304); #1;
    chk("t3_c4", ms_to_ws_valid, 1'b1);
    chk("t3_r1", ms_result[1], 32'h5555_AAAA);
    chk("t3_r0", ms_result[0], 32'h0102_0304);
    step();

    // flush of a pending lw, stale response dropped
    idle(); pms_to_ms_valid = 1'b1; lane(0, LW, 2'd0, 32'h0, 32'h0); step();
    idle(); ms_flush = 1'b1; #1; chk("t4_flush_to_ws", ms_to_ws_valid, 1'b0); step();
    idle(); pms_to_ms_valid = 1'b1; lane(0, LW, 2'd0, 32'h0, 32'h0); #1;
    chk("t4_valid_clr", ms_fwd_valid, 1'b0); step();
    idle(); resp(0, 32'hDEAD); #1; chk("t4_stale", ms_to_ws_valid, 1'b0); step();
    idle(); resp(0, 32'h1234); #1;
    chk("t4_done", ms_to_ws_valid, 1'b1);
    chk("t4_r0", ms_result[0], 32'h0000_1234);
    step();

    // lane 3 lhu; invalid lanes carrying memory flags must not block
    idle(); pms_to_ms_valid = 1'b1; lane(0, 7'd0, 2'd0, 32'h0, 32'h77); lane(3, LHU, 2'd2, 32'h0, 32'h0);
    pms_res_from_mem[2:1] = 2'b11; step();
    idle(); resp(3, 32'hF00D_0000); #1;
    chk("t5_to_ws", ms_to_ws_valid, 1'b1);
    chk("t5_r3", ms_result[3], 32'h0000_F00D);
    step();

    // reset during a stall with a capture and two pending drops
    for (int k = 0; k < 2; k++) begin
      idle(); pms_to_ms_valid = 1'b1; lane(0, LW, 2'd0, 32'h0, 32'h0); step();
      idle(); ms_flush = 1'b1; step();
    end
    idle(); pms_to_ms_valid = 1'b1; lane(0, LW, 2'd0, 32'h0, 32'h0); lane(1, LW, 2'd0, 32'h0, 32'h0); step();
    idle(); ws_allowin = 1'b0; resp(1, 32'h2222); step();
    idle(); ws_allowin = 1'b0; reset = 1'b1; step();
    idle(); #1;
    chk("t6_allowin", ms_allowin, 1'b1);
    chk("t6_valid", ms_fwd_valid, 1'b0);
    chk("t6_to_ws", ms_to_ws_valid, 1'b0);
    pms_to_ms_valid = 1'b1; lane(0, LW, 2'd0, 32'h0, 32'h0); step();
    idle(); resp(0, 32'hCAFE); #1;
    chk("t6_nodrop", ms_to_ws_valid, 1'b1);
    chk("t6_r0", ms_result[0], 32'h0000_CAFE);
    step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int k;
      idle();
      reset           = ($urandom % 80) == 0;
      ms_flush        = ($urandom % 12) == 0;
      ws_allowin      = ($urandom % 4) != 0;
      pms_to_ms_valid = $urandom % 2;
      for (int i = 0; i < L; i++) begin
        k = $urandom % 3;
        pms_lane_valid[i]   = (i == 0) || ($urandom % 2);
        pms_res_from_mem[i] = (k == 1);
        pms_mem_we[i]       = (k == 2);
        pms_load_type[i]    = (k == 1) ? 7'(1 << ($urandom % 7)) : 7'd0;
        pms_gr_we[i]        = (k != 2) && ($urandom % 4 != 0);
        pms_offset[i]       = 2'($urandom);
        pms_dest[i]         = 5'($urandom);
        pms_rt_value[i]     = $urandom;
        pms_alu_result[i]   = $urandom;
        pms_pc[i]           = $urandom;
        data_cache_data_ok[i] = ($urandom % 3) == 0;
        data_cache_rdata[i]   = $urandom;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
